// File: rtl/isa_io_responder_if.sv
// ISA I/O target pin bundle plus the register-side write/read handshakes.
// The slave modport is the responder; the master modport is the pins plus the register file.
interface isa_io_responder_if #(
    parameter int ADDR_BITS = 4
);
    logic [9:0]           isa_addr;
    logic                 isa_aen;
    logic                 isa_iow_n;
    logic                 isa_ior_n;
    logic [7:0]           isa_data_in;
    logic [7:0]           isa_data_out;
    logic                 isa_data_oe;
    logic                 isa_iochrdy;
    logic                 wr_valid;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;
    logic                 wr_ready;
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           rd_data;
    logic                 rd_ack;
    logic                 err_timeout;
    logic [2:0]           state_debug;

    modport slave (
        input  isa_addr, isa_aen, isa_iow_n, isa_ior_n, isa_data_in,
        input  wr_ready, rd_data, rd_ack,
        output isa_data_out, isa_data_oe, isa_iochrdy,
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output err_timeout, state_debug
    );

    modport master (
        output isa_addr, isa_aen, isa_iow_n, isa_ior_n, isa_data_in,
        output wr_ready, rd_data, rd_ack,
        input  isa_data_out, isa_data_oe, isa_iochrdy,
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  err_timeout, state_debug
    );
endinterface

// File: rtl/isa_io_responder.sv
// ISA I/O target: decodes IOW#/IOR# cycles in a 2^ADDR_BITS port window, forwards them to the
// register side over valid/ready and req/ack handshakes, and stretches the bus cycle with IOCHRDY.
module isa_io_responder #(
    parameter logic [9:0] BASE_ADDR   = 10'h220,
    parameter int         ADDR_BITS   = 4,
    parameter int         TIMEOUT     = 64,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    isa_io_responder_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PEND  = 3'd1,
        ST_WR_HOLD  = 3'd2,
        ST_RD_PEND  = 3'd3,
        ST_RD_DRIVE = 3'd4
    } state_t;

    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_iow_sync;
    logic [SYNC_STAGES-1:0] r_ior_sync;
    logic                   r_iow_prev;
    logic                   r_ior_prev;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [7:0]             r_wr_data;
    logic [ADDR_BITS-1:0]   r_rd_addr;
    logic [7:0]             r_dout;
    logic                   r_iochrdy;
    logic                   r_err;

    state_t                 w_nxt_state;
    logic [CNT_W-1:0]       w_nxt_cnt;
    logic [ADDR_BITS-1:0]   w_nxt_wr_addr;
    logic [7:0]             w_nxt_wr_data;
    logic [ADDR_BITS-1:0]   w_nxt_rd_addr;
    logic [7:0]             w_nxt_dout;
    logic                   w_nxt_iochrdy;
    logic                   w_nxt_err;

    logic w_iow_s;
    logic w_ior_s;
    logic w_iow_fall;
    logic w_ior_fall;
    logic w_hit;

    // Synchronisers clear to 0 so a strobe already low at reset release never looks like an edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!reset) begin
            r_iow_sync <= '0;
            r_ior_sync <= '0;
            r_iow_prev <= 1'b0;
            r_ior_prev <= 1'b0;
        end else begin
            r_iow_sync <= {r_iow_sync[SYNC_STAGES-2:0], bus.isa_iow_n};
            r_ior_sync <= {r_ior_sync[SYNC_STAGES-2:0], bus.isa_ior_n};
            r_iow_prev <= w_iow_s;
            r_ior_prev <= w_ior_s;
        end
    end

    assign w_iow_s    = r_iow_sync[SYNC_STAGES-1];
    assign w_ior_s    = r_ior_sync[SYNC_STAGES-1];
    assign w_iow_fall = r_iow_prev && !w_iow_s;
    assign w_ior_fall = r_ior_prev && !w_ior_s;
    assign w_hit      = !bus.isa_aen && (bus.isa_addr[9:ADDR_BITS] == BASE_ADDR[9:ADDR_BITS]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
            r_rd_addr <= '0;
            r_dout    <= 8'h00;
            r_iochrdy <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_wr_addr <= w_nxt_wr_addr;
            r_wr_data <= w_nxt_wr_data;
            r_rd_addr <= w_nxt_rd_addr;
            r_dout    <= w_nxt_dout;
            r_iochrdy <= w_nxt_iochrdy;
            r_err     <= w_nxt_err;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_wr_addr = r_wr_addr;
        w_nxt_wr_data = r_wr_data;
        w_nxt_rd_addr = r_rd_addr;
        w_nxt_dout    = r_dout;
        w_nxt_iochrdy = r_iochrdy;
        w_nxt_err     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hit && w_iow_fall && !w_ior_fall) begin
                    w_nxt_state   = ST_WR_PEND;
                    w_nxt_cnt     = '0;
                    w_nxt_wr_addr = bus.isa_addr[ADDR_BITS-1:0];
                    w_nxt_wr_data = bus.isa_data_in;
                    w_nxt_iochrdy = 1'b0;
                end else if (w_hit && w_ior_fall && !w_iow_fall) begin
                    w_nxt_state   = ST_RD_PEND;
                    w_nxt_cnt     = '0;
                    w_nxt_rd_addr = bus.isa_addr[ADDR_BITS-1:0];
                    w_nxt_iochrdy = 1'b0;
                end
            end

            // A write is never dropped on strobe release; only IOCHRDY is let go early.
            ST_WR_PEND: begin
                if (bus.wr_ready) begin
                    w_nxt_iochrdy = 1'b1;
                    w_nxt_state   = w_iow_s ? ST_IDLE : ST_WR_HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_err     = 1'b1;
                    w_nxt_iochrdy = 1'b1;
                    w_nxt_state   = ST_WR_HOLD;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                    if (w_iow_s) begin
                        w_nxt_iochrdy = 1'b1;
                    end
                end
            end

            ST_WR_HOLD: begin
                if (w_iow_s) begin
                    w_nxt_state = ST_IDLE;
                end
            end

            // Strobe release beats a same-cycle ack: the host has already stopped sampling SD.
            ST_RD_PEND: begin
                if (w_ior_s) begin
                    w_nxt_iochrdy = 1'b1;
                    w_nxt_state   = ST_IDLE;
                end else if (bus.rd_ack) begin
                    w_nxt_dout    = bus.rd_data;
                    w_nxt_iochrdy = 1'b1;
                    w_nxt_state   = ST_RD_DRIVE;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_dout    = 8'hFF;
                    w_nxt_err     = 1'b1;
                    w_nxt_iochrdy = 1'b1;
                    w_nxt_state   = ST_RD_DRIVE;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end

            ST_RD_DRIVE: begin
                if (w_ior_s) begin
                    w_nxt_state = ST_IDLE;
                end
            end

            default: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_iochrdy = 1'b1;
            end
        endcase
    end

    assign bus.wr_valid     = (r_state == ST_WR_PEND);
    assign bus.rd_req       = (r_state == ST_RD_PEND);
    assign bus.isa_data_oe  = (r_state == ST_RD_DRIVE);
    assign bus.isa_data_out = r_dout;
    assign bus.isa_iochrdy  = r_iochrdy;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.rd_addr      = r_rd_addr;
    assign bus.err_timeout  = r_err;
    assign bus.state_debug  = r_state;
endmodule
